zbreak: RTL and testbench
=========================

// Module: zbreak
// PURPOSE
//  Z80 opcode-fetch breakpoint unit, upstream of the NMI generator. Holds up to
//  NUM_BP programmable 16-bit breakpoint addresses and watches M1 opcode fetches.
//  On a match it raises imm_nmi. It drops imm_nmi when the NMI handler is entered
//  (in_nmi=1). After in_nmi returns to 0, it skips one fetch so that execution
//  resumes at the breakpoint address without re-triggering.
// PARAMETERS
//  NUM_BP   4   number of breakpoint slots, legal range 1..4
// PORTS
//  fclk      in   1   system clock; single clock domain
//  rst_n     in   1   asynchronous active-low reset
//  zpos      in   1   one-fclk strobe at Z80 clock rising edge
//  zneg      in   1   one-fclk strobe at Z80 clock falling edge
//  m1_n      in   1   Z80 /M1
//  mreq_n    in   1   Z80 /MREQ
//  a         in   16  Z80 address bus
//  in_nmi    in   1   NMI-handler-active level, from the NMI generator
//  cfg_wr    in   1   one-fclk configuration write strobe
//  cfg_addr  in   4   configuration register index
//  cfg_wdata in   8   configuration write data
//  cfg_rdata out  8   configuration read data; combinational mux on cfg_addr
//  imm_nmi   out  1   breakpoint NMI request, level; consumer detects the rising edge
//  bp_hit    out  1   one-fclk pulse on each accepted hit
// BEHAVIOUR
//  Register map:
//   - 2n: slot n address[7:0]; 2n+1: slot n address[15:8] (n < NUM_BP)
//   - 8: enable mask, bits [NUM_BP-1:0]; unused bits read 0
//   - 9: status. Read: [3:0] hit flags, [7] timeout flag. Write: 1 clears the
//     matching bit
//   - Unmapped indices read 0x00; writes to them are ignored
//  Fetch detection:
//   - m1_n is registered on zpos; mreq_n is registered on zneg
//   - was_m1 = both registered values low
//   - fetch_stb = rising edge of was_m1 (one fclk)
//   - On fetch_stb, a is compared against every enabled slot, using register
//     contents from before any cfg_wr in the same cycle
//  FSM states: IDLE, FIRE, HANDLER, SKIP. Reset state is IDLE.
//   - IDLE: fetch_stb with at least one match and in_nmi=0 -> FIRE
//       * Set flags of all matching slots
//       * Pulse bp_hit
//       * imm_nmi=1 from the next fclk
//     Matches while in_nmi=1 are ignored.
//   - FIRE: imm_nmi held at 1; 8-bit timeout counter cleared on entry and
//     incremented on each zpos.
//       * in_nmi=1 -> HANDLER, imm_nmi=0
//       * Counter reaches 255 with in_nmi still 0 -> IDLE, imm_nmi=0, status[7]=1
//       * in_nmi rising on the same cycle as timeout: HANDLER wins, no flag
//   - HANDLER: ignore all fetches; in_nmi=0 -> SKIP
//   - SKIP: next fetch_stb is discarded, matched or not -> IDLE.
//     in_nmi=1 while in SKIP -> HANDLER.
//  Other rules:
//   - Simultaneous cfg_wr to status and a new hit: the hit sets its flag; the set
//     wins over the clear
//   - Reset (any time, including FIRE):
//       * All addresses 0x0000, enable mask 0, status 0
//       * State IDLE, imm_nmi=0, bp_hit=0, counter 0
//       * Registered m1_n/mreq_n are set to 1
//   - All registers use async reset; no latches; cfg_rdata has no reset (combinational)
// STRUCTURE
//  Shared package:
//   - register indices: BP_ADDR_BASE=0, BP_EN=8, BP_STAT=9
//   - FSM state encoding: 2-bit localparams
//   - TIMEOUT_MAX=255
//  Sub-module zbreak_slot, one per slot:
//   - holds its 16-bit address and its enable bit
//   - decodes its two cfg indices
//   - outputs match = en && (a == addr)
//  Top level: fetch detector, FSM, status register, read mux.
// TESTING
//  1. Write slot0=0x1234 and mask=0x01; M1 fetch at 0x1234 -> bp_hit pulses one
//     fclk after fetch_stb, imm_nmi=1, status reads 0x01.
//  2. Non-M1 memory read at 0x1234 (m1_n=1), and an M1 fetch at 0x1235 ->
//     no bp_hit, imm_nmi stays 0.
//  3. After a hit, set in_nmi=1 -> imm_nmi=0 next fclk; fetches at 0x1234 ignored.
//     Set in_nmi=0; the first 0x1234 fetch is ignored and the second hits.
//  4. slot0=slot2=0x0066, mask=0x05; fetch at 0x0066 -> status=0x05, one bp_hit
//     pulse. Then write 0x01 to index 9 -> status=0x04.
//  5. Hit, then hold in_nmi=0 for 256 zpos -> imm_nmi falls, FSM returns to IDLE,
//     status[7]=1.
//  6. Assert rst_n=0 in FIRE -> imm_nmi=0 immediately; after release, all
//     registers read 0x00 and a fetch at 0x0000 does not hit.

Source files
------------

// File: rtl/zbreak_pkg.sv
// Shared definitions for the Z80 opcode-fetch breakpoint unit.
package zbreak_pkg;

   localparam logic [3:0] BP_ADDR_BASE = 4'd0;
   localparam logic [3:0] BP_EN        = 4'd8;
   localparam logic [3:0] BP_STAT      = 4'd9;

   localparam logic [7:0] TIMEOUT_MAX  = 8'd255;

   // Upper bound on slot count; the register map only has room for four slots.
   localparam int MAX_BP = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FIRE    = 2'd1,
      ST_HANDLER = 2'd2,
      ST_SKIP    = 2'd3
   } state_t;

endpackage

// File: rtl/zbreak_slot.sv
// One breakpoint slot: a 16-bit address, an enable bit, and the comparator.
module zbreak_slot
   import zbreak_pkg::*;
#(
   parameter int IDX = 0
) (
   input  logic        fclk,
   input  logic        rst_n,
   input  logic        cfg_wr,
   input  logic [3:0]  cfg_addr,
   input  logic [7:0]  cfg_wdata,
   input  logic [15:0] a,
   output logic [15:0] addr,
   output logic        en,
   output logic        match
);

   localparam logic [3:0] LO_IDX = BP_ADDR_BASE + 4'(2 * IDX);
   localparam logic [3:0] HI_IDX = LO_IDX + 4'd1;

   logic [15:0] addr_q, addr_d;
   logic        en_q, en_d;

   // Decode this slot's two address bytes and its bit of the enable mask.
   always_comb begin
      addr_d = addr_q;
      en_d   = en_q;
      if (cfg_wr) begin
         if (cfg_addr == LO_IDX) addr_d[7:0]  = cfg_wdata;
         if (cfg_addr == HI_IDX) addr_d[15:8] = cfg_wdata;
         if (cfg_addr == BP_EN)  en_d         = cfg_wdata[IDX];
      end
   end

   // Slot configuration registers.
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= 16'h0000;
         en_q   <= 1'b0;
      end else begin
         addr_q <= addr_d;
         en_q   <= en_d;
      end
   end

   assign addr  = addr_q;
   assign en    = en_q;
   // Compares against the registered address, so a same-cycle write is not seen.
   assign match = en_q && (a == addr_q);

endmodule

// File: rtl/zbreak.sv
// Z80 opcode-fetch breakpoint unit: fetch detector, breakpoint FSM,
// status register and configuration read mux.
module zbreak
   import zbreak_pkg::*;
#(
   parameter int NUM_BP = 4
) (
   input  logic        fclk,
   input  logic        rst_n,
   input  logic        zpos,
   input  logic        zneg,
   input  logic        m1_n,
   input  logic        mreq_n,
   input  logic [15:0] a,
   input  logic        in_nmi,
   input  logic        cfg_wr,
   input  logic [3:0]  cfg_addr,
   input  logic [7:0]  cfg_wdata,
   output logic [7:0]  cfg_rdata,
   output logic        imm_nmi,
   output logic        bp_hit
);

   logic [15:0] slot_addr [MAX_BP];
   logic [3:0]  en_vec;
   logic [3:0]  match_vec;

   for (genvar g = 0; g < MAX_BP; g++) begin : g_slot
      if (g < NUM_BP) begin : g_on
         zbreak_slot #(.IDX(g)) u_slot (
            .fclk      (fclk),
            .rst_n     (rst_n),
            .cfg_wr    (cfg_wr),
            .cfg_addr  (cfg_addr),
            .cfg_wdata (cfg_wdata),
            .a         (a),
            .addr      (slot_addr[g]),
            .en        (en_vec[g]),
            .match     (match_vec[g])
         );
      end else begin : g_off
         assign slot_addr[g] = 16'h0000;
         assign en_vec[g]    = 1'b0;
         assign match_vec[g] = 1'b0;
      end
   end

   // ---------------- fetch detector ----------------
   logic m1_q, m1_d;
   logic mreq_q, mreq_d;
   logic was_m1_q, was_m1_d;
   logic fetch_stb;

   // Sample /M1 on the Z80 rising edge and /MREQ on the falling edge.
   always_comb begin
      m1_d     = zpos ? m1_n : m1_q;
      mreq_d   = zneg ? mreq_n : mreq_q;
      was_m1_d = ~m1_q & ~mreq_q;
   end

   // Fetch detector registers; idle bus levels after reset.
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         m1_q     <= 1'b1;
         mreq_q   <= 1'b1;
         was_m1_q <= 1'b0;
      end else begin
         m1_q     <= m1_d;
         mreq_q   <= mreq_d;
         was_m1_q <= was_m1_d;
      end
   end

   assign fetch_stb = was_m1_d & ~was_m1_q;

   // ---------------- FSM and status ----------------
   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] stat_q, stat_d;
   logic       bp_hit_q, bp_hit_d;

   // Next state, timeout counter and status flags; hit sets are applied after
   // the write-one-to-clear so a simultaneous hit keeps its flag.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stat_d   = stat_q;
      bp_hit_d = 1'b0;

      if (cfg_wr && (cfg_addr == BP_STAT))
         stat_d = stat_q & ~cfg_wdata;

      case (state_q)
         ST_IDLE: begin
            if (fetch_stb && (|match_vec) && !in_nmi) begin
               state_d     = ST_FIRE;
               cnt_d       = 8'd0;
               bp_hit_d    = 1'b1;
               stat_d[3:0] = stat_d[3:0] | match_vec;
            end
         end
         ST_FIRE: begin
            if (in_nmi) begin
               state_d = ST_HANDLER;
            end else if (cnt_q == TIMEOUT_MAX) begin
               state_d   = ST_IDLE;
               stat_d[7] = 1'b1;
            end else if (zpos) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_HANDLER: begin
            if (!in_nmi) state_d = ST_SKIP;
         end
         ST_SKIP: begin
            if (in_nmi)         state_d = ST_HANDLER;
            else if (fetch_stb) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM, counter, status and hit-pulse registers.
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 8'd0;
         stat_q   <= 8'h00;
         bp_hit_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         stat_q   <= stat_d;
         bp_hit_q <= bp_hit_d;
      end
   end

   assign imm_nmi = (state_q == ST_FIRE);
   assign bp_hit  = bp_hit_q;

   // ---------------- read mux ----------------
   // Combinational register readback; unmapped indices read zero.
   always_comb begin
      cfg_rdata = 8'h00;
      if (!cfg_addr[3]) begin
         if (int'(cfg_addr[2:1]) < NUM_BP)
            cfg_rdata = cfg_addr[0] ? slot_addr[cfg_addr[2:1]][15:8]
                                    : slot_addr[cfg_addr[2:1]][7:0];
      end else if (cfg_addr == BP_EN) begin
         cfg_rdata = {4'h0, en_vec};
      end else if (cfg_addr == BP_STAT) begin
         cfg_rdata = stat_q;
      end
   end

endmodule

// File: tb/tb_zbreak.sv
// Directed testbench for the zbreak breakpoint unit.
module tb_zbreak;

   logic        fclk = 1'b0;
   logic        rst_n;
   logic        zpos, zneg, m1_n, mreq_n, in_nmi, cfg_wr;
   logic [15:0] a;
   logic [3:0]  cfg_addr;
   logic [7:0]  cfg_wdata;
   logic [7:0]  cfg_rdata;
   logic        imm_nmi, bp_hit;

   int n_vec = 0;
   int n_bad = 0;
   int pulse_cnt = 0;

   zbreak #(.NUM_BP(4)) dut (
      .fclk      (fclk),
      .rst_n     (rst_n),
      .zpos      (zpos),
      .zneg      (zneg),
      .m1_n      (m1_n),
      .mreq_n    (mreq_n),
      .a         (a),
      .in_nmi    (in_nmi),
      .cfg_wr    (cfg_wr),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_rdata (cfg_rdata),
      .imm_nmi   (imm_nmi),
      .bp_hit    (bp_hit)
   );

   always #5 fclk = ~fclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge fclk);
      #1;
      if (bp_hit) pulse_cnt++;
   endtask

   task automatic cfg_write(input logic [3:0] idx, input logic [7:0] d);
      cfg_addr  = idx;
      cfg_wdata = d;
      cfg_wr    = 1'b1;
      tick();
      cfg_wr    = 1'b0;
   endtask

   task automatic rd(input logic [3:0] idx, output logic [7:0] d);
      cfg_addr = idx;
      #1;
      d = cfg_rdata;
   endtask

   task automatic zpos_pulse;
      zpos = 1'b1;
      tick();
      zpos = 1'b0;
      tick();
   endtask

   // One Z80 memory cycle; counts bp_hit pulses and whether the pulse lands one
   // fclk after the fetch strobe. Optionally clears all status bits in the hit cycle.
   task automatic do_fetch(input logic [15:0] addr, input bit is_m1, input bit clr_at_hit,
                           output int hits, output bit on_time);
      int start;
      start   = pulse_cnt;
      on_time = 1'b0;
      a       = addr;
      m1_n    = ~is_m1;
      zpos    = 1'b1;
      tick();
      zpos    = 1'b0;
      mreq_n  = 1'b0;
      zneg    = 1'b1;
      tick();
      zneg    = 1'b0;
      if (clr_at_hit) begin
         cfg_addr  = 4'd9;
         cfg_wdata = 8'hFF;
         cfg_wr    = 1'b1;
      end
      tick();
      cfg_wr  = 1'b0;
      on_time = bp_hit;
      m1_n    = 1'b1;
      mreq_n  = 1'b1;
      zpos    = 1'b1;
      tick();
      zpos    = 1'b0;
      zneg    = 1'b1;
      tick();
      zneg    = 1'b0;
      tick();
      hits = pulse_cnt - start;
   endtask

   // Handler entry/exit followed by the discarded resume fetch.
   task automatic nmi_round_trip;
      int  h;
      bit  ot;
      in_nmi = 1'b1;
      tick();
      in_nmi = 1'b0;
      tick();
      do_fetch(16'h0000, 1'b1, 1'b0, h, ot);
   endtask

   task automatic test_reset;
      logic [7:0] d;
      n_vec++; if (imm_nmi !== 1'b0) begin n_bad++; $display("FAIL reset_imm_nmi got %b want 0", imm_nmi); end
      n_vec++; if (bp_hit !== 1'b0) begin n_bad++; $display("FAIL reset_bp_hit got %b want 0", bp_hit); end
      rd(4'd0, d);
      n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_addr0 got %h want 00", d); end
      rd(4'd8, d);
      n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_mask got %h want 00", d); end
      rd(4'd9, d);
      n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_status got %h want 00", d); end
   endtask

   task automatic test_hit;
      logic [7:0] d;
      int  h;
      bit  ot;
      cfg_write(4'd0, 8'h34);
      cfg_write(4'd1, 8'h12);
      cfg_write(4'd8, 8'h01);
      rd(4'd1, d);
      n_vec++; if (d !== 8'h12) begin n_bad++; $display("FAIL hit_addr_hi got %h want 12", d); end
      do_fetch(16'h1234, 1'b1, 1'b0, h, ot);
      n_vec++; if (h !== 1) begin n_bad++; $display("FAIL hit_pulses got %0d want 1", h); end
      n_vec++; if (ot !== 1'b1) begin n_bad++; $display("FAIL hit_timing got %b want 1", ot); end
      n_vec++; if (imm_nmi !== 1'b1) begin n_bad++; $display("FAIL hit_imm_nmi got %b want 1", imm_nmi); end
      rd(4'd9, d);
      n_vec++; if (d !== 8'h01) begin n_bad++; $display("FAIL hit_status got %h want 01", d); end
   endtask

   task automatic test_nmi_skip;
      logic [7:0] d;
      int  h;
      bit  ot;
      in_nmi = 1'b1;
      tick();
      n_vec++; if (imm_nmi !== 1'b0) begin n_bad++; $display("FAIL nmi_drop got %b want 0", imm_nmi); end
      do_fetch(16'h1234, 1'b1, 1'b0, h, ot);
      n_vec++; if (h !== 0) begin n_bad++; $display("FAIL nmi_handler_fetch got %0d want 0", h); end
      in_nmi = 1'b0;
      tick();
      do_fetch(16'h1234, 1'b1, 1'b0, h, ot);
      n_vec++; if (h !== 0) begin n_bad++; $display("FAIL nmi_skip_fetch got %0d want 0", h); end
      n_vec++; if (imm_nmi !== 1'b0) begin n_bad++; $display("FAIL nmi_skip_imm got %b want 0", imm_nmi); end
      do_fetch(16'h1234, 1'b1, 1'b0, h, ot);
      n_vec++; if (h !== 1) begin n_bad++; $display("FAIL nmi_rehit got %0d want 1", h); end
      n_vec++; if (imm_nmi !== 1'b1) begin n_bad++; $display("FAIL nmi_rehit_imm got %b want 1", imm_nmi); end
      nmi_round_trip();
      cfg_write(4'd9, 8'hFF);
      rd(4'd9, d);
      n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL nmi_stat_clear got %h want 00", d); end
   endtask

   task automatic test_no_match;
      int  h;
      bit  ot;
      do_fetch(16'h1234, 1'b0, 1'b0, h, ot);
      n_vec++; if (h !== 0) begin n_bad++; $display("FAIL nomatch_non_m1 got %0d want 0", h); end
      do_fetch(16'h1235, 1'b1, 1'b0, h, ot);
      n_vec++; if (h !== 0) begin n_bad++; $display("FAIL nomatch_addr got %0d want 0", h); end
      n_vec++; if (imm_nmi !== 1'b0) begin n_bad++; $display("FAIL nomatch_imm got %b want 0", imm_nmi); end
   endtask

   task automatic test_multi;
      logic [7:0] d;
      int  h;
      bit  ot;
      cfg_write(4'd0, 8'h66);
      cfg_write(4'd1, 8'h00);
      cfg_write(4'd4, 8'h66);
      cfg_write(4'd5, 8'h00);
      cfg_write(4'd8, 8'h05);
      cfg_write(4'd10, 8'hAA);
      rd(4'd10, d);
      n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL multi_unmapped got %h want 00", d); end
      rd(4'd8, d);
      n_vec++; if (d !== 8'h05) begin n_bad++; $display("FAIL multi_mask got %h want 05", d); end
      do_fetch(16'h0066, 1'b1, 1'b0, h, ot);
      n_vec++; if (h !== 1) begin n_bad++; $display("FAIL multi_pulses got %0d want 1", h); end
      rd(4'd9, d);
      n_vec++; if (d !== 8'h05) begin n_bad++; $display("FAIL multi_status got %h want 05", d); end
      cfg_write(4'd9, 8'h01);
      rd(4'd9, d);
      n_vec++; if (d !== 8'h04) begin n_bad++; $display("FAIL multi_clear got %h want 04", d); end
      nmi_round_trip();
   endtask

   task automatic test_set_wins;
      logic [7:0] d;
      int  h;
      bit  ot;
      do_fetch(16'h0066, 1'b1, 1'b1, h, ot);
      n_vec++; if (h !== 1) begin n_bad++; $display("FAIL setwins_pulses got %0d want 1", h); end
      rd(4'd9, d);
      n_vec++; if (d !== 8'h05) begin n_bad++; $display("FAIL setwins_status got %h want 05", d); end
      nmi_round_trip();
   endtask

   task automatic test_timeout;
      logic [7:0] d;
      int  h;
      bit  ot;
      cfg_write(4'd9, 8'hFF);
      do_fetch(16'h0066, 1'b1, 1'b0, h, ot);
      n_vec++; if (h !== 1) begin n_bad++; $display("FAIL tmo_hit got %0d want 1", h); end
      for (int i = 0; i < 250; i++) zpos_pulse();
      n_vec++; if (imm_nmi !== 1'b1) begin n_bad++; $display("FAIL tmo_early got %b want 1", imm_nmi); end
      for (int i = 0; i < 6; i++) zpos_pulse();
      n_vec++; if (imm_nmi !== 1'b0) begin n_bad++; $display("FAIL tmo_imm got %b want 0", imm_nmi); end
      rd(4'd9, d);
      n_vec++; if (d !== 8'h85) begin n_bad++; $display("FAIL tmo_status got %h want 85", d); end
      do_fetch(16'h0066, 1'b1, 1'b0, h, ot);
      n_vec++; if (h !== 1) begin n_bad++; $display("FAIL tmo_idle_rehit got %0d want 1", h); end
   endtask

   task automatic test_reset_in_fire;
      logic [7:0] d;
      int  h;
      bit  ot;
      n_vec++; if (imm_nmi !== 1'b1) begin n_bad++; $display("FAIL rstfire_pre got %b want 1", imm_nmi); end
      rst_n = 1'b0;
      #1;
      n_vec++; if (imm_nmi !== 1'b0) begin n_bad++; $display("FAIL rstfire_imm got %b want 0", imm_nmi); end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         rd(4'(i), d);
         n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL rstfire_reg%0d got %h want 00", i, d); end
      end
      tick();
      rd(4'd8, d);
      n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL rstfire_mask got %h want 00", d); end
      rd(4'd9, d);
      n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL rstfire_status got %h want 00", d); end
      do_fetch(16'h0000, 1'b1, 1'b0, h, ot);
      n_vec++; if (h !== 0) begin n_bad++; $display("FAIL rstfire_fetch got %0d want 0", h); end
      n_vec++; if (imm_nmi !== 1'b0) begin n_bad++; $display("FAIL rstfire_imm_after got %b want 0", imm_nmi); end
   endtask

   initial begin
      rst_n     = 1'b0;
      zpos      = 1'b0;
      zneg      = 1'b0;
      m1_n      = 1'b1;
      mreq_n    = 1'b1;
      a         = 16'h0000;
      in_nmi    = 1'b0;
      cfg_wr    = 1'b0;
      cfg_addr  = 4'd0;
      cfg_wdata = 8'h00;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      test_reset();
      test_hit();
      test_nmi_skip();
      test_no_match();
      test_multi();
      test_set_wins();
      test_timeout();
      test_reset_in_fire();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
